// File: rtl/esteira_pkg.sv
// esteira_pkg: state encoding and destination codes for the conveyor arbiter.
// The FALHA state exists only when ESTEIRA_WATCHDOG_EN is defined.
package esteira_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_MOVENDO    = 3'd1;
   localparam logic [2:0] ST_PAUSADO    = 3'd2;
   localparam logic [2:0] ST_ASSENTANDO = 3'd3;
   localparam logic [2:0] ST_CONCLUIDO  = 3'd4;
   localparam logic [2:0] ST_AGUARDA    = 3'd5;
`ifdef ESTEIRA_WATCHDOG_EN
   localparam logic [2:0] ST_FALHA      = 3'd6;
`endif

   typedef enum logic [2:0] {
      IDLE           = ST_IDLE,
      MOVENDO        = ST_MOVENDO,
      PAUSADO        = ST_PAUSADO,
      ASSENTANDO     = ST_ASSENTANDO,
      CONCLUIDO      = ST_CONCLUIDO,
      AGUARDA_LIBERA = ST_AGUARDA
`ifdef ESTEIRA_WATCHDOG_EN
      , FALHA        = ST_FALHA
`endif
   } estado_t;

   localparam logic [1:0] DEST_NENHUM     = 2'd0;
   localparam logic [1:0] DEST_ENCHIMENTO = 2'd1;
   localparam logic [1:0] DEST_CQ         = 2'd2;
   localparam logic [1:0] DEST_FINAL      = 2'd3;

   // Picks the signal that belongs to destination d.
   function automatic logic sel_destino(
      input logic [1:0] d,
      input logic       e,
      input logic       c,
      input logic       f
   );
      logic r;
      r = 1'b0;
      unique case (d)
         DEST_ENCHIMENTO: r = e;
         DEST_CQ:         r = c;
         DEST_FINAL:      r = f;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sincronizador_sensor.sv
// sincronizador_sensor: 2-flop synchronizer for raw switch inputs.
// Asynchronous active-low reset clears both stages.
module sincronizador_sensor (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/arbitro_esteira.sv
// arbitro_esteira: grants one conveyor move at a time and sequences the motor.
// Watchdog and FALHA state are built only with ESTEIRA_WATCHDOG_EN.
module arbitro_esteira
   import esteira_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 250_000_000,
   parameter int SETTLE_CICLOS  = 2_500_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_enchimento,
   input  logic       req_cq,
   input  logic       req_final,
   input  logic       sensor_enchimento,
   input  logic       sensor_cq,
   input  logic       sensor_final,
   input  logic       pausa,
   input  logic       limpar_falha,
   output logic       motor_ligado,
   output logic       concluida_enchimento,
   output logic       concluida_cq,
   output logic       concluida_final,
   output logic [1:0] destino_atual,
   output logic       falha_timeout
);

   localparam int SW = $clog2(SETTLE_CICLOS + 1);
   localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CICLOS - 1);

   logic sen_e, sen_c, sen_f, pausa_s;

   sincronizador_sensor u_s_ench (
      .clk(clk), .reset_n(reset_n), .d(sensor_enchimento), .q(sen_e));
   sincronizador_sensor u_s_cq (
      .clk(clk), .reset_n(reset_n), .d(sensor_cq), .q(sen_c));
   sincronizador_sensor u_s_final (
      .clk(clk), .reset_n(reset_n), .d(sensor_final), .q(sen_f));
   sincronizador_sensor u_s_pausa (
      .clk(clk), .reset_n(reset_n), .d(pausa), .q(pausa_s));

   estado_t       estado, estado_nxt;
   logic [1:0]    destino, destino_nxt;
   logic [SW-1:0] assenta, assenta_nxt;
   logic          req_g, sen_g;

`ifdef ESTEIRA_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CICLOS);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CICLOS - 1);
   logic [WW-1:0] wd, wd_nxt;
`else
   logic unused_cfg;
   assign unused_cfg = limpar_falha ^ (TIMEOUT_CICLOS > 1);
`endif

   assign req_g = sel_destino(destino, req_enchimento, req_cq, req_final);
   assign sen_g = sel_destino(destino, sen_e, sen_c, sen_f);

   always_comb begin
      estado_nxt  = estado;
      destino_nxt = destino;
      assenta_nxt = '0;
`ifdef ESTEIRA_WATCHDOG_EN
      wd_nxt      = wd;
`endif
      unique case (estado)
         IDLE: begin
`ifdef ESTEIRA_WATCHDOG_EN
            wd_nxt = '0;
`endif
            if (req_final || req_cq || req_enchimento) begin
               // downstream stations drain first
               priority case (1'b1)
                  req_final: destino_nxt = DEST_FINAL;
                  req_cq:    destino_nxt = DEST_CQ;
                  default:   destino_nxt = DEST_ENCHIMENTO;
               endcase
               if (sel_destino(destino_nxt, sen_e, sen_c, sen_f))
                  estado_nxt = ASSENTANDO;
               else
                  estado_nxt = MOVENDO;
            end
         end
         MOVENDO: begin
            if (!req_g)
               estado_nxt = IDLE;
            else if (sen_g)
               estado_nxt = ASSENTANDO;
            else if (pausa_s)
               estado_nxt = PAUSADO;
`ifdef ESTEIRA_WATCHDOG_EN
            else if (wd == WD_MAX)
               estado_nxt = FALHA;
            else
               wd_nxt = wd + 1'b1;
`endif
         end
         PAUSADO: begin
            if (!req_g)
               estado_nxt = IDLE;
            else if (!pausa_s)
               estado_nxt = MOVENDO;
         end
         ASSENTANDO: begin
            if (!req_g)
               estado_nxt = IDLE;
            else if (assenta == SET_MAX)
               estado_nxt = CONCLUIDO;
            else
               assenta_nxt = assenta + 1'b1;
         end
         CONCLUIDO: estado_nxt = AGUARDA_LIBERA;
         AGUARDA_LIBERA: begin
            if (!req_g)
               estado_nxt = IDLE;
         end
`ifdef ESTEIRA_WATCHDOG_EN
         FALHA: begin
            if (limpar_falha && !req_final && !req_cq && !req_enchimento)
               estado_nxt = IDLE;
         end
`endif
         default: estado_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado  <= IDLE;
         destino <= DEST_NENHUM;
         assenta <= '0;
`ifdef ESTEIRA_WATCHDOG_EN
         wd      <= '0;
`endif
      end else begin
         estado  <= estado_nxt;
         destino <= destino_nxt;
         assenta <= assenta_nxt;
`ifdef ESTEIRA_WATCHDOG_EN
         wd      <= wd_nxt;
`endif
      end
   end

   assign motor_ligado = (estado == MOVENDO);
   assign concluida_enchimento =
      (estado == CONCLUIDO) && (destino == DEST_ENCHIMENTO);
   assign concluida_cq =
      (estado == CONCLUIDO) && (destino == DEST_CQ);
   assign concluida_final =
      (estado == CONCLUIDO) && (destino == DEST_FINAL);
   assign destino_atual = (estado == IDLE) ? DEST_NENHUM : destino;
`ifdef ESTEIRA_WATCHDOG_EN
   assign falha_timeout = (estado == FALHA);
`else
   assign falha_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_esteira.sv
// tb_arbitro_esteira: scenario tasks plus a completion-pulse scoreboard.
// Fault scenarios adapt to ESTEIRA_WATCHDOG_EN.
module tb_arbitro_esteira;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_enchimento, req_cq, req_final;
   logic       sensor_enchimento, sensor_cq, sensor_final;
   logic       pausa, limpar_falha;
   logic       motor_ligado;
   logic       concluida_enchimento, concluida_cq, concluida_final;
   logic [1:0] destino_atual;
   logic       falha_timeout;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   arbitro_esteira #(
      .TIMEOUT_CICLOS(100),
      .SETTLE_CICLOS (4)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .req_enchimento      (req_enchimento),
      .req_cq              (req_cq),
      .req_final           (req_final),
      .sensor_enchimento   (sensor_enchimento),
      .sensor_cq           (sensor_cq),
      .sensor_final        (sensor_final),
      .pausa               (pausa),
      .limpar_falha        (limpar_falha),
      .motor_ligado        (motor_ligado),
      .concluida_enchimento(concluida_enchimento),
      .concluida_cq        (concluida_cq),
      .concluida_final     (concluida_final),
      .destino_atual       (destino_atual),
      .falha_timeout       (falha_timeout)
   );

   always #5 clk = ~clk;

   // Every completion pulse must match the oldest expected one.
   always @(negedge clk) begin
      logic [2:0] c;
      logic [2:0] e;
      c = {concluida_final, concluida_cq, concluida_enchimento};
      if (c != 3'b000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pulse got %b required none", c);
         end else begin
            e = exp_q.pop_front();
            if (c !== e) begin
               errors++;
               $display("FAIL sb_pulse got %b required %b", c, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      {req_enchimento, req_cq, req_final} = 3'b000;
      {sensor_enchimento, sensor_cq, sensor_final} = 3'b000;
      pausa = 1'b0;
      limpar_falha = 1'b0;
      tick(3);
      checks++;
      if ({motor_ligado, concluida_final, concluida_cq,
           concluida_enchimento, destino_atual, falha_timeout}
          !== 7'b0) begin
         errors++;
         $display("FAIL reset_outs got %b required 0", {motor_ligado,
            destino_atual, falha_timeout});
      end
      reset_n = 1'b1;
      tick(2);
      checks++;
      if ({motor_ligado, destino_atual, falha_timeout} !== 4'b0) begin
         errors++;
         $display("FAIL idle_outs got %b required 0",
            {motor_ligado, destino_atual, falha_timeout});
      end
   endtask

   task automatic test_cq();
      exp_q.push_back(3'b010);
      req_cq = 1'b1;
      tick(1);
      checks++;
      if (motor_ligado !== 1'b1) begin
         errors++;
         $display("FAIL cq_motor_on got %b required 1", motor_ligado);
      end
      for (int i = 0; i < 9; i++) begin
         tick(1);
         checks++;
         if ({motor_ligado, destino_atual} !== 3'b110) begin
            errors++;
            $display("FAIL cq_moving got %b required 110",
               {motor_ligado, destino_atual});
         end
      end
      sensor_cq = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         checks++;
         if (motor_ligado !== (i < 3)) begin
            errors++;
            $display("FAIL cq_motor_off[%0d] got %b required %b",
               i, motor_ligado, (i < 3));
         end
         checks++;
         if (concluida_cq !== (i == 7)) begin
            errors++;
            $display("FAIL cq_pulse[%0d] got %b required %b",
               i, concluida_cq, (i == 7));
         end
         checks++;
         if (destino_atual !== 2'd2) begin
            errors++;
            $display("FAIL cq_dest[%0d] got %0d required 2",
               i, destino_atual);
         end
      end
      req_cq = 1'b0;
      sensor_cq = 1'b0;
      tick(1);
      checks++;
      if (destino_atual !== 2'd0) begin
         errors++;
         $display("FAIL cq_release got %0d required 0", destino_atual);
      end
      tick(3);
   endtask

   task automatic test_prioridade();
      int n;
      exp_q.push_back(3'b100);
      exp_q.push_back(3'b001);
      req_enchimento = 1'b1;
      req_final = 1'b1;
      tick(1);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b111) begin
         errors++;
         $display("FAIL prio_grant got %b required 111",
            {motor_ligado, destino_atual});
      end
      sensor_final = 1'b1;
      n = 0;
      while (concluida_final !== 1'b1 && n < 30) begin
         tick(1);
         n++;
      end
      checks++;
      if (concluida_final !== 1'b1) begin
         errors++;
         $display("FAIL prio_final_done got 0 required 1");
      end
      tick(3);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b011) begin
         errors++;
         $display("FAIL prio_hold got %b required 011",
            {motor_ligado, destino_atual});
      end
      req_final = 1'b0;
      sensor_final = 1'b0;
      tick(1);
      checks++;
      if (destino_atual !== 2'd0) begin
         errors++;
         $display("FAIL prio_idle got %0d required 0", destino_atual);
      end
      tick(1);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b101) begin
         errors++;
         $display("FAIL prio_ench_grant got %b required 101",
            {motor_ligado, destino_atual});
      end
      sensor_enchimento = 1'b1;
      n = 0;
      while (concluida_enchimento !== 1'b1 && n < 30) begin
         tick(1);
         n++;
      end
      checks++;
      if (concluida_enchimento !== 1'b1) begin
         errors++;
         $display("FAIL prio_ench_done got 0 required 1");
      end
      req_enchimento = 1'b0;
      sensor_enchimento = 1'b0;
      tick(4);
   endtask

   task automatic test_watchdog();
`ifdef ESTEIRA_WATCHDOG_EN
      int on;
      on = 0;
      req_cq = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (motor_ligado !== 1'b1) break;
         on++;
      end
      checks++;
      if (on != 100) begin
         errors++;
         $display("FAIL wd_on_cycles got %0d required 100", on);
      end
      checks++;
      if ({falha_timeout, motor_ligado} !== 2'b10) begin
         errors++;
         $display("FAIL wd_fault got %b required 10",
            {falha_timeout, motor_ligado});
      end
      limpar_falha = 1'b1;
      tick(1);
      checks++;
      if (falha_timeout !== 1'b1) begin
         errors++;
         $display("FAIL wd_clear_req_high got %b required 1",
            falha_timeout);
      end
      req_cq = 1'b0;
      tick(1);
      checks++;
      if ({falha_timeout, destino_atual} !== 3'b000) begin
         errors++;
         $display("FAIL wd_cleared got %b required 000",
            {falha_timeout, destino_atual});
      end
      limpar_falha = 1'b0;
      tick(2);
`else
      int bad;
      bad = 0;
      req_cq = 1'b1;
      for (int i = 0; i < 150; i++) begin
         tick(1);
         if ({motor_ligado, falha_timeout} !== 2'b10) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL nowd_wait got %0d bad cycles required 0", bad);
      end
      req_cq = 1'b0;
      tick(1);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b000) begin
         errors++;
         $display("FAIL nowd_abort got %b required 000",
            {motor_ligado, destino_atual});
      end
      tick(2);
`endif
   endtask

   task automatic test_pausa();
      int on;
      int off;
      on = 0;
      off = 0;
      req_cq = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if (i == 30) pausa = 1'b1;
         if (i == 50) pausa = 1'b0;
         tick(1);
         if (falha_timeout === 1'b1) break;
         if (motor_ligado === 1'b1) on++;
         else off++;
      end
      checks++;
      if (off != 20) begin
         errors++;
         $display("FAIL pause_off got %0d required 20", off);
      end
`ifdef ESTEIRA_WATCHDOG_EN
      checks++;
      if (on != 100 || falha_timeout !== 1'b1) begin
         errors++;
         $display("FAIL pause_wd got on=%0d flt=%b required 100 1",
            on, falha_timeout);
      end
      req_cq = 1'b0;
      limpar_falha = 1'b1;
      tick(1);
      limpar_falha = 1'b0;
`else
      checks++;
      if (on != 130) begin
         errors++;
         $display("FAIL pause_on got %0d required 130", on);
      end
      req_cq = 1'b0;
      tick(1);
`endif
      checks++;
      if ({motor_ligado, falha_timeout, destino_atual} !== 4'b0) begin
         errors++;
         $display("FAIL pause_end got %b required 0000",
            {motor_ligado, falha_timeout, destino_atual});
      end
      tick(3);
   endtask

   task automatic test_aborto();
      int pulses;
      pulses = 0;
      req_enchimento = 1'b1;
      tick(5);
      checks++;
      if (motor_ligado !== 1'b1) begin
         errors++;
         $display("FAIL abort_moving got %b required 1", motor_ligado);
      end
      req_enchimento = 1'b0;
      tick(1);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle got %b required 000",
            {motor_ligado, destino_atual});
      end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (concluida_enchimento === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_no_pulse got %0d required 0", pulses);
      end
   endtask

   task automatic test_sensor_ja_ativo();
      int at;
      int on;
      at = 0;
      on = 0;
      sensor_final = 1'b1;
      tick(3);
      exp_q.push_back(3'b100);
      req_final = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         if (motor_ligado === 1'b1) on++;
         if (concluida_final === 1'b1) at = i;
      end
      checks++;
      if (on != 0) begin
         errors++;
         $display("FAIL pre_motor got %0d on cycles required 0", on);
      end
      checks++;
      if (at != 5) begin
         errors++;
         $display("FAIL pre_pulse_at got %0d required 5", at);
      end
      req_final = 1'b0;
      sensor_final = 1'b0;
      tick(4);
   endtask

   task automatic test_reset_meio();
      req_cq = 1'b1;
      tick(5);
      checks++;
      if (motor_ligado !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre got %b required 1", motor_ligado);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({motor_ligado, concluida_final, concluida_cq,
           concluida_enchimento, destino_atual, falha_timeout}
          !== 7'b0) begin
         errors++;
         $display("FAIL rst_async got %b required 0",
            {motor_ligado, destino_atual, falha_timeout});
      end
      req_cq = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      checks++;
      if ({motor_ligado, destino_atual} !== 3'b000) begin
         errors++;
         $display("FAIL rst_after got %b required 000",
            {motor_ligado, destino_atual});
      end
   endtask

   initial begin
      test_reset();
      test_cq();
      test_prioridade();
      test_watchdog();
      test_pausa();
      test_aborto();
      test_sensor_ja_ativo();
      test_reset_meio();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitro_esteira.md
# arbitro_esteira

Arbiter and sequencer for the single conveyor motor. It sits between the master sequencer's three level-held move commands (to filling, to QC, to final) and the physical motor/sensor pins. It grants one move at a time and runs the motor until the target position sensor fires. After a settle delay it returns a one-cycle completion pulse, and it trips a watchdog fault if the target sensor is never reached.

## Interface
- TIMEOUT_CICLOS, 250_000_000: maximum non-paused motor-on cycles per move (5 s at 50 MHz); minimum 2.
- SETTLE_CICLOS, 2_500_000: motor-off settle cycles before completion (50 ms); minimum 1.
- clk  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_enchimento / req_cq / req_final  in  1 each  level requests; held high until the matching completion pulse.
- sensor_enchimento / sensor_cq / sensor_final  in  1 each  raw position switches (asynchronous), active high.
- pausa  in  1  raw pause input (e.g. cork alarm), active high.
- limpar_falha  in  1  clears a latched fault.
- motor_ligado  out  1  conveyor motor enable.
- concluida_enchimento / concluida_cq / concluida_final  out  1 each  one-cycle completion pulses.
- destino_atual  out  2  granted target: 0 none, 1 filling, 2 QC, 3 final.
- falha_timeout  out  1  watchdog fault, latched.

## Operation
- All sensor inputs and pausa pass through 2-flop synchronizers. All state logic uses only the synchronized versions.
- States:
  - IDLE: destino_atual=0.
  - MOVENDO: motor on.
  - PAUSADO: motor off, move still granted.
  - ASSENTANDO: motor off, settle counter running.
  - CONCLUIDO: completion pulse.
  - AGUARDA_LIBERA: waiting for the request to drop.
  - FALHA: fault latched.
- Outputs are a Moore decode of the state register plus the latched destination.
  - motor_ligado = (state==MOVENDO).
  - concluida_x = (state==CONCLUIDO && destino==x).
  - falha_timeout = (state==FALHA).
- IDLE:
  - Grant goes to the highest-priority asserted request: final > cq > enchimento (drain downstream first). Latch destino and clear the watchdog counter.
  - If the target's synchronized sensor is already high, go to ASSENTANDO; otherwise go to MOVENDO.
- MOVENDO:
  - Target sensor high -> ASSENTANDO. This has priority over pause and timeout.
  - Else pausa high -> PAUSADO.
  - Else the counter increments. When it reaches TIMEOUT_CICLOS-1 -> FALHA.
- PAUSADO:
  - The counter holds.
  - pausa low -> MOVENDO.
- ASSENTANDO: counts SETTLE_CICLOS cycles, then -> CONCLUIDO. pausa is ignored here.
- CONCLUIDO: lasts exactly one cycle, then -> AGUARDA_LIBERA.
- AGUARDA_LIBERA: granted request low -> IDLE. This prevents re-grant from the master's one-cycle-late command release.
- FALHA: motor off. Exits to IDLE only when limpar_falha=1 and all three requests are low.
- Abort rule: if the granted request drops in MOVENDO, PAUSADO or ASSENTANDO, go to IDLE next cycle with no completion pulse.
- Non-granted requests are ignored until IDLE. No preemption.
- Reset: state IDLE, counters 0, synchronizers 0.
  - Outputs are all 0: motor_ligado, all concluida_x, destino_atual, falha_timeout.
  - Reset mid-move drops motor_ligado immediately (asynchronous).
- Watchdog counter width is $clog2(TIMEOUT_CICLOS); settle counter width is $clog2(SETTLE_CICLOS+1). Neither counter ever wraps.

## Timing
- Request sampled high at edge n in IDLE -> motor_ligado=1 from edge n.
- Sensor pin rises before edge k -> synchronized high after edge k+1 -> motor_ligado=0 after edge k+2.
- Pause path: the same 2-cycle synchronization plus 1 cycle state latency.
- Motor-off to completion pulse: SETTLE_CICLOS cycles in ASSENTANDO, then the pulse in the next cycle.
- Fault: the motor stays on for exactly TIMEOUT_CICLOS non-paused cycles, then falha_timeout=1.

## Configuration
- ESTEIRA_WATCHDOG_EN defined: the watchdog counter and FALHA state exist as described.
- ESTEIRA_WATCHDOG_EN undefined:
  - No watchdog counter and no FALHA state.
  - falha_timeout is tied to 0 and limpar_falha is unused.
  - MOVENDO waits on the sensor indefinitely.
  - TIMEOUT_CICLOS is ignored.

## Structure
- Shared package esteira_pkg holds:
  - state encoding localparams;
  - destination codes DEST_NENHUM=0, DEST_ENCHIMENTO=1, DEST_CQ=2, DEST_FINAL=3.
- Sub-module sincronizador_sensor: 2-flop synchronizer with async active-low reset. It is instantiated four times (three sensors plus pausa).

## Test plan
(Bench parameters: TIMEOUT_CICLOS=100, SETTLE_CICLOS=4.)
- req_cq high; raise sensor_cq 10 cycles later:
  - motor_ligado=1 the cycle after the request;
  - motor_ligado=0 3 edges after the sensor rises;
  - concluida_cq pulses for 1 cycle after 4 settle cycles;
  - destino_atual=2 throughout.
- req_enchimento and req_final raised in the same cycle -> destino_atual=3 (final) granted. Filling is granted only after final completes and req_final drops.
- Move with no sensor:
  - falha_timeout=1 after 100 motor-on cycles, motor off;
  - limpar_falha=1 with all requests low -> IDLE.
- pausa high for 20 cycles mid-move:
  - motor off for the paused span;
  - timeout still fires after 100 cumulative motor-on cycles.
- Request dropped during MOVENDO -> IDLE, no concluida pulse.
- req_final with sensor_final already high -> motor never on; concluida_final after settle.
- reset_n low mid-move -> motor_ligado=0 immediately, all outputs 0.
